// File: rtl/cook_sequencer.sv
// ---------------------------------------------------------------------------
// cook_sequencer
//   Microwave cook controller. Owns the mm:ss BCD time register and the cook
//   FSM. It steers the external timer_controler through enablen: low selects
//   keypad entry (pgt_1Hz is a key strobe), high selects the 1 Hz countdown
//   (pgt_1Hz is a second tick).
//
// Optional feature macro: QUICK_START_EN
//   defined   : start in IDLE at 00:00 (door closed) loads QUICK_ADD_S and
//               cooks; start while cooking adds QUICK_ADD_S (BCD, sat 99:59)
//   undefined : start in IDLE and in COOK is ignored
//
// Ports
//   clk          100 Hz system clock
//   clearn       asynchronous active-low reset
//   bcd[3:0]     keypad digit from timer_controler
//   loadn        key-valid from timer_controler (status only, not used)
//   pgt_1Hz      key strobe (entry) / second tick (cook), asynchronous
//   startn       active-low debounced start button
//   stopn        active-low debounced stop/clear button
//   door_closed  1 = door closed
//   enablen      timer_controler mode select (0 entry, 1 countdown)
//   min_tens, min_ones, sec_tens, sec_ones   BCD time digits
//   mag_on       magnetron enable
//   done_beep    beeper enable
//   state[2:0]   FSM state code
// ---------------------------------------------------------------------------
module cook_sequencer #(
  parameter int DONE_BEEP_S = 3,
  parameter int QUICK_ADD_S = 30
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] bcd,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done_beep,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int BEEP_W = (DONE_BEEP_S > 1) ? $clog2(DONE_BEEP_S) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(DONE_BEEP_S - 1);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [2:0] pgt_sync_q;   // [1:0] synchroniser, [2] edge history
  logic [1:0] startn_q;
  logic [1:0] stopn_q;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      pgt_sync_q <= 3'b000;
      startn_q   <= 2'b11;    // released, so reset release gives no event
      stopn_q    <= 2'b11;
    end else begin
      pgt_sync_q <= {pgt_sync_q[1:0], pgt_1Hz};
      startn_q   <= {startn_q[0], startn};
      stopn_q    <= {stopn_q[0], stopn};
    end
  end

  logic tick, start_ev, stop_ev;
  assign tick     = pgt_sync_q[1] & ~pgt_sync_q[2];
  assign start_ev = startn_q[1] & ~startn_q[0];
  assign stop_ev  = stopn_q[1] & ~stopn_q[0];

  logic unused_loadn;
  assign unused_loadn = loadn;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic [15:0]       time_q,     time_d;      // {mt, mo, st, so}
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic [1:0]        blank_q,    blank_d;
  logic              enablen_q,  enablen_d;
  logic              mag_on_q,   mag_on_d;
  logic              done_beep_q, done_beep_d;

  // BCD countdown by one second. Only the seconds borrow clamps to 5:9;
  // an entered tens-of-seconds above 5 simply counts down through it.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // ---------------------------------------------------------------------
  // Quick start adder
  // ---------------------------------------------------------------------
  logic        quick_en;
  logic [15:0] quick_time;

`ifdef QUICK_START_EN
  localparam int QA_MIN = QUICK_ADD_S / 60;
  localparam int QA_SEC = QUICK_ADD_S % 60;
  localparam logic [3:0] QA_SO = 4'(QA_SEC % 10);
  localparam logic [3:0] QA_ST = 4'(QA_SEC / 10);
  localparam logic [3:0] QA_MO = 4'(QA_MIN % 10);
  localparam logic [3:0] QA_MT = 4'((QA_MIN / 10) % 10);

  // Digit-wise BCD add; tens-of-seconds carries at 6. A carry out of the
  // minutes-tens digit saturates the whole display at 99:59.
  function automatic logic [15:0] quick_add(input logic [15:0] t);
    logic [4:0] s;
    logic       c;
    logic [3:0] mt, mo, st, so;
    s  = {1'b0, t[3:0]} + {1'b0, QA_SO};
    c  = (s >= 5'd10);
    so = c ? 4'(s - 5'd10) : s[3:0];
    s  = {1'b0, t[7:4]} + {1'b0, QA_ST} + {4'b0, c};
    c  = (s >= 5'd6);
    st = c ? 4'(s - 5'd6) : s[3:0];
    s  = {1'b0, t[11:8]} + {1'b0, QA_MO} + {4'b0, c};
    c  = (s >= 5'd10);
    mo = c ? 4'(s - 5'd10) : s[3:0];
    s  = {1'b0, t[15:12]} + {1'b0, QA_MT} + {4'b0, c};
    c  = (s >= 5'd10);
    mt = c ? 4'(s - 5'd10) : s[3:0];
    if (c) return 16'h9959;
    return {mt, mo, st, so};
  endfunction

  assign quick_en   = 1'b1;
  assign quick_time = quick_add(time_q);
`else
  logic [31:0] unused_quick_add;
  assign unused_quick_add = QUICK_ADD_S;
  assign quick_en         = 1'b0;
  assign quick_time       = time_q;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic. Branch order encodes the same-cycle priority:
  // stop > door open > start > tick.
  // ---------------------------------------------------------------------
  logic        tick_ok, key_ok, time_zero;
  logic [15:0] time_dec;

  // timer_controler switches its pgt_1Hz source on enablen changes; ticks
  // seen while blank_q is non-zero are glitches of that switch.
  assign tick_ok   = tick & (blank_q == 2'd0);
  assign key_ok    = tick_ok & (bcd <= 4'd9);
  assign time_zero = (time_q == 16'h0000);
  assign time_dec  = dec_time(time_q);

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    beep_cnt_d = (state_q == S_DONE) ? beep_cnt_q : '0;

    case (state_q)
      S_IDLE: begin
        if (stop_ev) begin
          time_d = 16'h0000;
        end else if (quick_en && start_ev && door_closed && time_zero) begin
          time_d  = quick_time;
          state_d = S_COOK;
        end else if (key_ok) begin
          time_d  = {time_q[11:0], bcd};
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (stop_ev) begin
          time_d  = 16'h0000;
          state_d = S_IDLE;
        end else if (start_ev && door_closed && !time_zero) begin
          state_d = S_COOK;
        end else if (key_ok) begin
          time_d = {time_q[11:0], bcd};
        end
      end

      S_COOK: begin
        if (stop_ev || !door_closed) begin
          state_d = S_PAUSE;
        end else if (quick_en && start_ev) begin
          time_d = quick_time;
        end else if (tick_ok) begin
          time_d = time_dec;
          if (time_dec == 16'h0000) state_d = S_DONE;
        end
      end

      S_PAUSE: begin
        if (stop_ev) begin
          time_d  = 16'h0000;
          state_d = S_IDLE;
        end else if (start_ev && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        if (stop_ev) begin
          time_d  = 16'h0000;
          state_d = S_IDLE;
        end else if (tick_ok) begin
          if (beep_cnt_q == BEEP_LAST) begin
            time_d     = 16'h0000;
            state_d    = S_IDLE;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BEEP_W'(1);
          end
        end
      end

      default: begin
        time_d  = 16'h0000;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_comb begin
    enablen_d   = (state_d == S_COOK) || (state_d == S_PAUSE) || (state_d == S_DONE);
    mag_on_d    = (state_d == S_COOK);
    done_beep_d = (state_d == S_DONE);
    if (enablen_d != enablen_q)  blank_d = 2'd2;
    else if (blank_q != 2'd0)    blank_d = blank_q - 2'd1;
    else                         blank_d = 2'd0;
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q     <= S_IDLE;
      time_q      <= 16'h0000;
      beep_cnt_q  <= '0;
      blank_q     <= 2'd0;
      enablen_q   <= 1'b0;
      mag_on_q    <= 1'b0;
      done_beep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      beep_cnt_q  <= beep_cnt_d;
      blank_q     <= blank_d;
      enablen_q   <= enablen_d;
      mag_on_q    <= mag_on_d;
      done_beep_q <= done_beep_d;
    end
  end

  assign state     = state_q;
  assign enablen   = enablen_q;
  assign mag_on    = mag_on_q;
  assign done_beep = done_beep_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer. Expected output records are pushed
// to a scoreboard queue as stimulus is applied and popped against the DUT
// outputs once the stimulus has taken effect.
module tb_cook_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] bcd;
  logic       loadn, pgt_1Hz, startn, stopn, door_closed;
  logic       enablen, mag_on, done_beep;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] state;

  cook_sequencer #(.DONE_BEEP_S(3), .QUICK_ADD_S(30)) dut (
    .clk(clk), .clearn(clearn), .bcd(bcd), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .enablen(enablen), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .mag_on(mag_on),
    .done_beep(done_beep), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [21:0] exp;   // {state, mm:ss BCD, enablen, mag_on, done_beep}
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string      name;
    int         n;
    logic [3:0] k[5];
    logic [2:0] st;
    logic [15:0] t;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [21:0] dut_out();
    return {state, min_tens, min_ones, sec_tens, sec_ones, enablen, mag_on, done_beep};
  endfunction

  task automatic drain();
    sb_t e;
    logic [21:0] got;
    while (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      got = dut_out();
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got state=%0d time=%h en/mag/beep=%b, expected state=%0d time=%h en/mag/beep=%b",
                 e.name, got[21:19], got[18:3], got[2:0], e.exp[21:19], e.exp[18:3], e.exp[2:0]);
      end
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] st, input logic [15:0] t,
                            input logic en, input logic mag, input logic beep);
    sb_t e;
    e.name = name;
    e.exp  = {st, t, en, mag, beep};
    sb_q.push_back(e);
    drain();
  endtask

  // Tick acts on the 3rd rising edge after it is raised; sample just after.
  task automatic tick_pulse();
    @(negedge clk) pgt_1Hz = 1'b1;
    @(negedge clk) pgt_1Hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_pulse();
  endtask

  task automatic key(input logic [3:0] d);
    bcd   = d;
    loadn = 1'b0;
    tick_pulse();
    loadn = 1'b1;
  endtask

  // Button events act on the 2nd rising edge after the press.
  task automatic press_start();
    @(negedge clk) startn = 1'b0;
    @(negedge clk) startn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_stop();
    @(negedge clk) stopn = 1'b0;
    @(negedge clk) stopn = 1'b1;
    @(negedge clk);
  endtask

  task automatic to_idle();
    press_stop();
    press_stop();
  endtask

  initial begin
    vecs[0] = '{name: "entry_130",   n: 3, k: '{4'd1, 4'd3, 4'd0, 4'd0, 4'd0}, st: S_ENTRY, t: 16'h0130};
    vecs[1] = '{name: "entry_shift", n: 5, k: '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, st: S_ENTRY, t: 16'h2345};
    vecs[2] = '{name: "entry_bad",   n: 3, k: '{4'd7, 4'd12, 4'd5, 4'd0, 4'd0}, st: S_ENTRY, t: 16'h0075};
    vecs[3] = '{name: "idle_bad",    n: 1, k: '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0}, st: S_IDLE, t: 16'h0000};
    vecs[4] = '{name: "entry_9999",  n: 4, k: '{4'd9, 4'd9, 4'd9, 4'd9, 4'd0}, st: S_ENTRY, t: 16'h9999};

    clearn = 1'b0; bcd = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    repeat (3) @(negedge clk);
    expect_out("reset", S_IDLE, 16'h0000, 0, 0, 0);
    clearn = 1'b1;
    repeat (2) @(negedge clk);

    // Keypad entry table
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++) key(vecs[v].k[j]);
      expect_out(vecs[v].name, vecs[v].st, vecs[v].t, 0, 0, 0);
      press_stop();
      expect_out("entry_clear", S_IDLE, 16'h0000, 0, 0, 0);
    end

    // Full cook of 01:30 through DONE
    key(4'd1); key(4'd3); key(4'd0);
    door_closed = 1'b0;
    press_start();
    expect_out("start_door_open", S_ENTRY, 16'h0130, 0, 0, 0);
    door_closed = 1'b1;
    press_start();
    expect_out("cook_start", S_COOK, 16'h0130, 1, 1, 0);
    ticks(89);
    expect_out("cook_0001", S_COOK, 16'h0001, 1, 1, 0);
    tick_pulse();
    expect_out("done_enter", S_DONE, 16'h0000, 1, 0, 1);
    ticks(2);
    expect_out("done_beep2", S_DONE, 16'h0000, 1, 0, 1);
    tick_pulse();
    expect_out("done_exit", S_IDLE, 16'h0000, 0, 0, 0);

    // Start with zero time is ignored
    key(4'd0);
    press_start();
    expect_out("start_zero", S_ENTRY, 16'h0000, 0, 0, 0);
    press_stop();

    // Pause / resume / stop
    key(4'd0); key(4'd0); key(4'd5);
    press_start();
    @(negedge clk) door_closed = 1'b0;
    @(negedge clk);
    expect_out("door_pause", S_PAUSE, 16'h0005, 1, 0, 0);
    tick_pulse();
    expect_out("pause_hold", S_PAUSE, 16'h0005, 1, 0, 0);
    door_closed = 1'b1;
    press_start();
    expect_out("resume", S_COOK, 16'h0005, 1, 1, 0);
    tick_pulse();
    expect_out("resume_tick", S_COOK, 16'h0004, 1, 1, 0);
    press_stop();
    expect_out("stop_pause", S_PAUSE, 16'h0004, 1, 0, 0);
    press_stop();
    expect_out("stop_idle", S_IDLE, 16'h0000, 0, 0, 0);

    // Borrow chain
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press_start();
    tick_pulse();
    expect_out("borrow_1000", S_COOK, 16'h0959, 1, 1, 0);
    to_idle();
    key(4'd1); key(4'd9); key(4'd0);
    press_start();
    ticks(149);
    expect_out("cook_190_149", S_COOK, 16'h0001, 1, 1, 0);
    tick_pulse();
    expect_out("cook_190_150", S_DONE, 16'h0000, 1, 0, 1);
    press_stop();
    expect_out("done_stop", S_IDLE, 16'h0000, 0, 0, 0);

    // Same-cycle stop + start + tick in COOK
    key(4'd0); key(4'd2); key(4'd0);
    press_start();
    tick_pulse();
    expect_out("cook_0019", S_COOK, 16'h0019, 1, 1, 0);
    @(negedge clk) pgt_1Hz = 1'b1;
    @(negedge clk) begin pgt_1Hz = 1'b0; startn = 1'b0; stopn = 1'b0; end
    @(negedge clk) begin startn = 1'b1; stopn = 1'b1; end
    @(negedge clk);
    expect_out("prio_stop", S_PAUSE, 16'h0019, 1, 0, 0);
    press_stop();

    // Tick landing one clock after the enablen edge is blanked
    key(4'd0); key(4'd0); key(4'd9);
    @(negedge clk) begin startn = 1'b0; pgt_1Hz = 1'b1; end
    @(negedge clk) begin startn = 1'b1; pgt_1Hz = 1'b0; end
    repeat (3) @(negedge clk);
    expect_out("blank_tick", S_COOK, 16'h0009, 1, 1, 0);
    tick_pulse();
    expect_out("post_blank", S_COOK, 16'h0008, 1, 1, 0);
    to_idle();

    // Quick start
    press_start();
`ifdef QUICK_START_EN
    expect_out("quick_idle", S_COOK, 16'h0030, 1, 1, 0);
    to_idle();
`else
    expect_out("quick_idle", S_IDLE, 16'h0000, 0, 0, 0);
`endif
    key(4'd9); key(4'd9); key(4'd4); key(4'd6);
    press_start();
    tick_pulse();
    expect_out("cook_9945", S_COOK, 16'h9945, 1, 1, 0);
    press_start();
`ifdef QUICK_START_EN
    expect_out("quick_sat", S_COOK, 16'h9959, 1, 1, 0);
`else
    expect_out("quick_cook", S_COOK, 16'h9945, 1, 1, 0);
`endif

    // Asynchronous reset mid-cook
    @(negedge clk);
    #2 clearn = 1'b0;
    #1 expect_out("async_reset", S_IDLE, 16'h0000, 0, 0, 0);
    @(negedge clk) clearn = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
